// File: rtl/pll_ctrl_pkg.sv
// pll_ctrl_pkg: shared state enums, default timing and PLL phase-pin idle values
package pll_ctrl_pkg;
  typedef enum logic [1:0] {PLL_RST, WAIT_LOCK, STABLE, RUN} lock_state_t;
  typedef enum logic [2:0] {P_IDLE, P_SETUP, P_LOW, P_GAP, P_DONE} phase_state_t;
  localparam int RST_CYCLES_DEF    = 16;
  localparam int LOCK_TIMEOUT_DEF  = 250000;
  localparam int STABLE_CYCLES_DEF = 1024;
  localparam int STEP_SETUP_DEF    = 2;
  localparam int STEP_LOW_DEF      = 4;
  localparam int STEP_GAP_DEF      = 4;
  localparam logic [1:0] PHASESEL_IDLE  = 2'd0;
  localparam logic PHASEDIR_IDLE        = 1'b1;
  localparam logic PHASESTEP_IDLE       = 1'b1;
  localparam logic PHASELOADREG_IDLE    = 1'b1;
  function automatic int max3(input int a, input int b, input int c);
    return a > b ? (a > c ? a : c) : (b > c ? b : c);
  endfunction
endpackage

// File: rtl/pll_phase_stepper.sv
// pll_phase_stepper: turns a phase request into the PHASESEL/PHASEDIR/PHASESTEP sequence
module pll_phase_stepper
  import pll_ctrl_pkg::*;
#(
  parameter int STEP_SETUP = STEP_SETUP_DEF,
  parameter int STEP_LOW   = STEP_LOW_DEF,
  parameter int STEP_GAP   = STEP_GAP_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ready,
  input  logic       ps_req,
  input  logic [1:0] ps_sel,
  input  logic       ps_dir,
  input  logic [3:0] ps_count,
  output logic       ps_ack,
  output logic       ps_err,
  output logic [1:0] pll_phasesel,
  output logic       pll_phasedir,
  output logic       pll_phasestep
);
  localparam int TW = $clog2(max3(STEP_SETUP, STEP_LOW, STEP_GAP) + 1);
  phase_state_t state, state_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [3:0] rem, rem_n;
  logic [1:0] sel_q;
  logic dir_q, ack_n, err_n;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= P_IDLE;
      tcnt   <= '0;
      rem    <= '0;
      sel_q  <= PHASESEL_IDLE;
      dir_q  <= PHASEDIR_IDLE;
      ps_ack <= 1'b0;
      ps_err <= 1'b0;
    end else begin
      state  <= state_n;
      tcnt   <= tcnt_n;
      rem    <= rem_n;
      ps_ack <= ack_n;
      ps_err <= err_n;
      if (state == P_IDLE) begin
        sel_q <= ps_sel;
        dir_q <= ps_dir;
      end
    end
  end
  always_comb begin
    state_n = state;
    tcnt_n  = tcnt + TW'(1);
    rem_n   = rem;
    ack_n   = 1'b0;
    err_n   = 1'b0;
    case (state)
      P_IDLE: begin
        tcnt_n = '0;
        // the cycle carrying an ack never samples, so a level request is not acked twice
        if (ps_req && !ps_ack) begin
          if (!ready || ps_count == 4'd0) begin
            ack_n = 1'b1;
            err_n = !ready;
          end else begin
            state_n = P_SETUP;
            rem_n   = ps_count;
          end
        end
      end
      P_SETUP: if (tcnt == TW'(STEP_SETUP - 1)) begin
        state_n = P_LOW;
        tcnt_n  = '0;
      end
      P_LOW: if (tcnt == TW'(STEP_LOW - 1)) begin
        state_n = P_GAP;
        tcnt_n  = '0;
      end
      P_GAP: if (tcnt == TW'(STEP_GAP - 1)) begin
        tcnt_n  = '0;
        state_n = rem == 4'd1 ? P_DONE : P_LOW;
        rem_n   = rem - 4'd1;
      end
      P_DONE: begin
        state_n = P_IDLE;
        ack_n   = 1'b1;
      end
      default: state_n = P_IDLE;
    endcase
    if (!ready && (state == P_SETUP || state == P_LOW || state == P_GAP)) begin
      state_n = P_IDLE;
      ack_n   = 1'b1;
      err_n   = 1'b1;
    end
  end
  assign pll_phasesel  = state != P_IDLE ? sel_q : PHASESEL_IDLE;
  assign pll_phasedir  = state != P_IDLE ? dir_q : PHASEDIR_IDLE;
  assign pll_phasestep = state == P_LOW ? 1'b0 : PHASESTEP_IDLE;
endmodule

// File: rtl/pll_ctrl.sv
// pll_ctrl: EHXPLLL lock supervisor with SoC reset release and optional phase sequencer
// Define PLL_CTRL_PHASE_EN to build in the phase stepper; otherwise phase requests are rejected.
module pll_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int RST_CYCLES    = RST_CYCLES_DEF,
  parameter int LOCK_TIMEOUT  = LOCK_TIMEOUT_DEF,
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int STEP_SETUP    = STEP_SETUP_DEF,
  parameter int STEP_LOW      = STEP_LOW_DEF,
  parameter int STEP_GAP      = STEP_GAP_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       ready,
  output logic [7:0] retry_cnt,
  output logic [7:0] lock_loss_cnt,
  input  logic       ps_req,
  input  logic [1:0] ps_sel,
  input  logic       ps_dir,
  input  logic [3:0] ps_count,
  output logic       ps_ack,
  output logic       ps_err,
  output logic [1:0] pll_phasesel,
  output logic       pll_phasedir,
  output logic       pll_phasestep,
  output logic       pll_phaseloadreg
);
  localparam int CW = $clog2(max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES) + 1);
  lock_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic s1, locked_s, run_q, retry_inc, loss_inc;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1            <= 1'b0;
      locked_s      <= 1'b0;
      state         <= PLL_RST;
      cnt           <= '0;
      run_q         <= 1'b0;
      retry_cnt     <= '0;
      lock_loss_cnt <= '0;
    end else begin
      s1       <= pll_locked;
      locked_s <= s1;
      state    <= state_n;
      cnt      <= cnt_n;
      run_q    <= state_n == RUN;
      if (retry_inc && retry_cnt != 8'hff) retry_cnt <= retry_cnt + 8'd1;
      if (loss_inc && lock_loss_cnt != 8'hff) lock_loss_cnt <= lock_loss_cnt + 8'd1;
    end
  end
  always_comb begin
    state_n   = state;
    cnt_n     = cnt + CW'(1);
    retry_inc = 1'b0;
    loss_inc  = 1'b0;
    case (state)
      PLL_RST: if (cnt == CW'(RST_CYCLES - 1)) begin
        state_n = WAIT_LOCK;
        cnt_n   = '0;
      end
      WAIT_LOCK: if (locked_s) begin
        state_n = STABLE;
        cnt_n   = '0;
      end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
        state_n   = PLL_RST;
        cnt_n     = '0;
        retry_inc = 1'b1;
      end
      STABLE: if (!locked_s) begin
        state_n = WAIT_LOCK;
        cnt_n   = '0;
      end else if (cnt == CW'(STABLE_CYCLES - 1)) begin
        state_n = RUN;
        cnt_n   = '0;
      end
      default: begin
        cnt_n = '0;
        if (!locked_s) begin
          state_n  = WAIT_LOCK;
          loss_inc = 1'b1;
        end
      end
    endcase
  end
  assign pll_rst          = state == PLL_RST;
  assign sys_rst_n        = run_q;
  assign ready            = run_q;
  assign pll_phaseloadreg = PHASELOADREG_IDLE;
`ifdef PLL_CTRL_PHASE_EN
  pll_phase_stepper #(
    .STEP_SETUP(STEP_SETUP),
    .STEP_LOW  (STEP_LOW),
    .STEP_GAP  (STEP_GAP)
  ) u_stepper (
    .clk          (clk),
    .rst_n        (rst_n),
    .ready        (run_q),
    .ps_req       (ps_req),
    .ps_sel       (ps_sel),
    .ps_dir       (ps_dir),
    .ps_count     (ps_count),
    .ps_ack       (ps_ack),
    .ps_err       (ps_err),
    .pll_phasesel (pll_phasesel),
    .pll_phasedir (pll_phasedir),
    .pll_phasestep(pll_phasestep)
  );
`else
  logic ack_q, unused_ps;
  always_ff @(posedge clk) ack_q <= rst_n && ps_req && !ack_q;
  assign unused_ps     = ^{ps_sel, ps_dir, ps_count};
  assign ps_ack        = ack_q;
  assign ps_err        = ack_q;
  assign pll_phasesel  = PHASESEL_IDLE;
  assign pll_phasedir  = PHASEDIR_IDLE;
  assign pll_phasestep = PHASESTEP_IDLE;
`endif
endmodule

// File: tb/tb_pll_ctrl.sv
// tb_pll_ctrl: directed/randomized bench for pll_ctrl against a timing-formula reference model
module tb_pll_ctrl;
  localparam int RST = 16, LT = 100, SC = 8, S = 2, L = 4, G = 4, P = L + G;
`ifdef PLL_CTRL_PHASE_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif
  localparam logic [25:0] RVEC = {1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  logic clk = 1'b0, rst_n = 1'b0, pll_locked = 1'b0, ps_req = 1'b0, ps_dir = 1'b0;
  logic [1:0] ps_sel = 2'd0;
  logic [3:0] ps_count = 4'd0;
  logic pll_rst, sys_rst_n, ready, ps_ack, ps_err, pll_phasedir, pll_phasestep, pll_phaseloadreg;
  logic [7:0] retry_cnt, lock_loss_cnt;
  logic [1:0] pll_phasesel;
  int vectors = 0, miscompares = 0;

  pll_ctrl #(
    .RST_CYCLES(RST), .LOCK_TIMEOUT(LT), .STABLE_CYCLES(SC),
    .STEP_SETUP(S), .STEP_LOW(L), .STEP_GAP(G)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .pll_rst(pll_rst),
    .sys_rst_n(sys_rst_n), .ready(ready), .retry_cnt(retry_cnt), .lock_loss_cnt(lock_loss_cnt),
    .ps_req(ps_req), .ps_sel(ps_sel), .ps_dir(ps_dir), .ps_count(ps_count),
    .ps_ack(ps_ack), .ps_err(ps_err), .pll_phasesel(pll_phasesel), .pll_phasedir(pll_phasedir),
    .pll_phasestep(pll_phasestep), .pll_phaseloadreg(pll_phaseloadreg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [25:0] rvec();
    return {pll_rst, sys_rst_n, ready, retry_cnt, lock_loss_cnt, pll_phasesel,
            pll_phasedir, pll_phasestep, pll_phaseloadreg, ps_ack, ps_err};
  endfunction

  // step k (0 = cycle after acceptance) is low inside the L-cycle window of each P-cycle period
  function automatic bit exp_low(input int k, input int n, input int stop);
    int j;
    if (!EN || k >= stop || k < S) return 1'b0;
    j = k - S;
    return (j / P < n) && (j % P < L);
  endfunction

  task automatic phase_run(input int n, input int kd);
    int t_ack, stop, last, busy;
    logic [1:0] sel;
    logic dir;
    bit held;
    sel   = 2'($urandom);
    dir   = 1'($urandom);
    busy  = S + n * P + 1;
    stop  = kd >= 0 ? kd + 4 : 1 << 20;
    t_ack = (!EN || n == 0) ? 0 : (kd >= 0 ? stop : busy);
    last  = kd >= 0 ? kd + 8 : t_ack + 2;
    ps_sel = sel; ps_dir = dir; ps_count = 4'(n); ps_req = 1'b1;
    for (int k = 0; k <= last; k++) begin
      @(negedge clk);
      held = EN && n > 0 && k < (stop < busy ? stop : busy);
      chk("phasestep", 32'(pll_phasestep), 32'(!exp_low(k, n, stop)));
      chk("phasesel", 32'(pll_phasesel), 32'(held ? sel : 2'd0));
      chk("phasedir", 32'(pll_phasedir), 32'(held ? dir : 1'b1));
      chk("loadreg", 32'(pll_phaseloadreg), 32'd1);
      chk("ps_ack", 32'(ps_ack), 32'(k == t_ack));
      if (k == t_ack) chk("ps_err", 32'(ps_err), 32'(!EN || kd >= 0));
      if (kd >= 0) begin
        chk("sys_rst_n_loss", 32'(sys_rst_n), 32'(k < kd + 3));
        chk("lock_loss_cnt", 32'(lock_loss_cnt), 32'(k >= kd + 3));
      end else chk("ready_run", 32'(ready), 32'd1);
      if (k == 0) begin ps_sel = 2'($urandom); ps_dir = 1'($urandom); end
      if (k == t_ack) ps_req = 1'b0;
      if (kd >= 0 && k == kd) pll_locked = 1'b0;
    end
  endtask

  initial begin
    int t, g, d, r;
    repeat (3) @(negedge clk);
    chk("reset_vec", 32'(rvec()), 32'(RVEC));
    // bring-up with a rejected pre-lock request
    t = $urandom_range(20, 60);
    rst_n = 1'b1;
    for (int c = 1; c <= t + 14; c++) begin
      @(negedge clk);
      chk("pll_rst", 32'(pll_rst), 32'(c < RST));
      chk("sys_rst_n_up", 32'(sys_rst_n), 32'(c >= t + 3 + SC));
      chk("ready_up", 32'(ready), 32'(c >= t + 3 + SC));
      chk("retry_up", 32'(retry_cnt), 32'd0);
      chk("prelock_ack", 32'(ps_ack), 32'(c == 6));
      if (c == 6) chk("prelock_err", 32'(ps_err), 32'd1);
      chk("prelock_step", 32'(pll_phasestep), 32'd1);
      if (c == 5) begin ps_req = 1'b1; ps_count = 4'($urandom_range(1, 15)); end
      if (c == 6) ps_req = 1'b0;
      if (c == t) pll_locked = 1'b1;
    end
    phase_run(3, -1);
    phase_run($urandom_range(1, 15), -1);
    phase_run(0, -1);
    phase_run($urandom_range(3, 15), $urandom_range(S + P, S + P + L - 1));
    // lock glitch inside STABLE must restart qualification
    g = $urandom_range(2, 7);
    d = $urandom_range(1, 3);
    r = g + d;
    pll_locked = 1'b1;
    for (int c = 1; c <= r + 14; c++) begin
      @(negedge clk);
      chk("sys_rst_n_glitch", 32'(sys_rst_n), 32'(c >= r + 3 + SC));
      chk("ready_glitch", 32'(ready), 32'(c >= r + 3 + SC));
      chk("retry_glitch", 32'(retry_cnt), 32'd0);
      chk("loss_glitch", 32'(lock_loss_cnt), 32'd1);
      chk("pll_rst_glitch", 32'(pll_rst), 32'd0);
      pll_locked = (c < g) || (c >= r);
    end
    // reset mid-request: outputs to reset values, no ack afterwards
    ps_sel = 2'($urandom); ps_dir = 1'($urandom); ps_count = 4'($urandom_range(2, 5)); ps_req = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      if (k < 6) chk("midrst_ack", 32'(ps_ack), 32'(!EN && k == 0));
      else chk("midrst_vec", 32'(rvec()), 32'(RVEC));
      if (!EN && k == 0) ps_req = 1'b0;
      if (k == 5) begin rst_n = 1'b0; pll_locked = 1'b0; ps_req = 1'b0; end
    end
    // lock never arrives: periodic retries, saturating counter
    rst_n = 1'b1;
    for (int c = 1; c <= (RST + LT) * 302; c++) begin
      @(negedge clk);
      chk("pll_rst_retry", 32'(pll_rst), 32'((c % (RST + LT)) < RST));
      chk("retry_cnt", 32'(retry_cnt), 32'((c / (RST + LT)) > 255 ? 255 : c / (RST + LT)));
      chk("retry_noack", 32'(ps_ack), 32'd0);
      chk("retry_sysrst", 32'(sys_rst_n), 32'd0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
